vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/pixel_tick_gen.sv | 48 ++++
 rtl/vga_timing_gen.sv | 181 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA timing generator:
//   - 640x480@60 timing (25.175 MHz pixel clock class)
//   - 800x600@60 timing (40 MHz pixel clock class)
//   - the 8-entry colour-bar table, indexed by bar number, giving {R,G,B}
// -----------------------------------------------------------------------------
package vga_pkg;

    // 640x480 @ 60 Hz
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600 @ 60 Hz
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    // Colour bars: bar b drives R=b[2], G=b[1], B=b[0]
    // (black, blue, green, cyan, red, magenta, yellow, white).
    localparam logic [2:0] BAR_TABLE [8] = '{
        3'b000, 3'b001, 3'b010, 3'b011,
        3'b100, 3'b101, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
        return BAR_TABLE[bar];
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// -----------------------------------------------------------------------------
// pixel_tick_gen
// Clock-enable divider: o_pixel_tick is high for one clock out of every
// CLK_DIV clocks (constantly high when CLK_DIV = 1). The first tick appears
// CLK_DIV clocks after reset is released.
// Ports:
//   i_clock      system clock
//   i_reset      asynchronous active-high reset
//   o_pixel_tick registered one-clock pixel enable
// -----------------------------------------------------------------------------
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_pixel_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_err_clk_div
        $error("pixel_tick_gen: CLK_DIV must be in 1..16");
    end

    logic [DIV_W-1:0] r_div;
    logic             r_tick;

    // The tick is registered from the terminal count, so it lags the counter
    // by one clock; that lag is what places the first tick CLK_DIV clocks
    // after reset release.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == DIV_LAST);
            if (r_div == DIV_LAST) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_pixel_tick = r_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator with colour-bar test pattern.
// Stage 1: pixel counters x/y advanced on pixel_tick.
// Stage 2: sync and colour registered on pixel_tick, one pixel after the
//          (x,y) they describe.
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   test_mode             1 = internal colour bars, 0 = rgb_in
//   rgb_in                external pixel {R,G,B}, sampled when pixel_req
//   x, y                  current counters
//   pixel_req             (x,y) inside the active area
//   pixel_tick            one-clock pixel enable
//   frame_start           pixel_tick at x=0,y=0
//   vgaRed/Green/Blue     colour out (registered)
//   Hsync, Vsync          sync out (registered, level set by SYNC_POL)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter int CLK_DIV    = 4,
    parameter int COLOR_BITS = 4,
    parameter int SYNC_POL   = 0
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic                                                  test_mode,
    input  logic [3*COLOR_BITS-1:0]                               rgb_in,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]          x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]          y,
    output logic                                                  pixel_req,
    output logic                                                  pixel_tick,
    output logic                                                  frame_start,
    output logic [COLOR_BITS-1:0]                                 vgaRed,
    output logic [COLOR_BITS-1:0]                                 vgaGreen,
    output logic [COLOR_BITS-1:0]                                 vgaBlue,
    output logic                                                  Hsync,
    output logic                                                  Vsync
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W      = $clog2(H_TOTAL);
    localparam int Y_W      = $clog2(V_TOTAL);
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int CW       = COLOR_BITS;

    localparam logic SYNC_ACT = (SYNC_POL != 0);

    // ---------------- parameter legality ----------------
    if (H_ACTIVE < 8 || (H_ACTIVE % 8) != 0) begin : g_err_h_active
        $error("vga_timing_gen: H_ACTIVE must be a non-zero multiple of 8");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_err_h_porch
        $error("vga_timing_gen: H_FP, H_SYNC and H_BP must be at least 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_v
        $error("vga_timing_gen: vertical timing parameters must be at least 1");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_err_clk_div
        $error("vga_timing_gen: CLK_DIV must be in 1..16");
    end
    if (COLOR_BITS < 1) begin : g_err_color_bits
        $error("vga_timing_gen: COLOR_BITS must be at least 1");
    end
    if (SYNC_POL != 0 && SYNC_POL != 1) begin : g_err_sync_pol
        $error("vga_timing_gen: SYNC_POL must be 0 or 1");
    end

    // ---------------- pixel enable ----------------
    logic w_tick;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .i_clock      (clock),
        .i_reset      (reset),
        .o_pixel_tick (w_tick)
    );

    // ---------------- stage 1: raster counters ----------------
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_tick) begin
            if (r_x == X_W'(H_TOTAL - 1)) begin
                r_x <= '0;
                if (r_y == Y_W'(V_TOTAL - 1)) begin
                    r_y <= '0;
                end else begin
                    r_y <= r_y + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    logic w_pixel_req;
    logic w_hs_on;
    logic w_vs_on;

    assign w_pixel_req = (r_x < X_W'(H_ACTIVE)) && (r_y < Y_W'(V_ACTIVE));
    assign w_hs_on     = (r_x >= X_W'(HS_FIRST)) && (r_x <= X_W'(HS_LAST));
    assign w_vs_on     = (r_y >= Y_W'(VS_FIRST)) && (r_y <= Y_W'(VS_LAST));

    // Bar index by threshold compare instead of a divide: only the active
    // region matters, so b saturates at 7 past the last bar boundary.
    logic [2:0] w_bar;
    always_comb begin
        w_bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (r_x >= X_W'(i * BAR_W)) begin
                w_bar = 3'(i);
            end
        end
    end

    logic [2:0]      w_bar_rgb;
    logic [3*CW-1:0] w_color_next;

    assign w_bar_rgb = bar_rgb(w_bar);

    always_comb begin
        w_color_next = '0;
        if (w_pixel_req) begin
            if (test_mode) begin
                w_color_next = {{CW{w_bar_rgb[2]}}, {CW{w_bar_rgb[1]}}, {CW{w_bar_rgb[0]}}};
            end else begin
                w_color_next = rgb_in;
            end
        end
    end

    // ---------------- stage 2: registered outputs ----------------
    // Reset drives syncs inactive at once, so a reset inside a sync pulse
    // truncates it at the reset edge.
    logic [3*CW-1:0] r_color;
    logic            r_hsync;
    logic            r_vsync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_color <= '0;
            r_hsync <= ~SYNC_ACT;
            r_vsync <= ~SYNC_ACT;
        end else if (w_tick) begin
            r_color <= w_color_next;
            r_hsync <= w_hs_on ? SYNC_ACT : ~SYNC_ACT;
            r_vsync <= w_vs_on ? SYNC_ACT : ~SYNC_ACT;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign pixel_req   = w_pixel_req;
    assign pixel_tick  = w_tick;
    assign frame_start = (r_x == '0) && (r_y == '0) && w_tick;
    assign vgaRed      = r_color[3*CW-1:2*CW];
    assign vgaGreen    = r_color[2*CW-1:CW];
    assign vgaBlue     = r_color[CW-1:0];
    assign Hsync       = r_hsync;
    assign Vsync       = r_vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- small instance: H 8/2/2/2, V 4/1/1/1, CLK_DIV=2 ----------------
    logic        rst_s, tm_s;
    logic [11:0] rgb_s;
    logic [3:0]  xs;
    logic [2:0]  ys;
    logic        req_s, tick_s, fs_s, hs_s, vs_s;
    logic [3:0]  rs, gs, bs;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .COLOR_BITS(4), .SYNC_POL(0)
    ) u_small (
        .clock(clk), .reset(rst_s), .test_mode(tm_s), .rgb_in(rgb_s),
        .x(xs), .y(ys), .pixel_req(req_s), .pixel_tick(tick_s),
        .frame_start(fs_s), .vgaRed(rs), .vgaGreen(gs), .vgaBlue(bs),
        .Hsync(hs_s), .Vsync(vs_s)
    );

    // ---------------- default instance (640x480, CLK_DIV=4) ----------------
    logic        rst_d, tm_d;
    logic [11:0] rgb_d;
    logic [9:0]  xd, yd;
    logic        req_d, tick_d, fs_d, hs_d, vs_d;
    logic [3:0]  rd, gd, bd;

    vga_timing_gen u_def (
        .clock(clk), .reset(rst_d), .test_mode(tm_d), .rgb_in(rgb_d),
        .x(xd), .y(yd), .pixel_req(req_d), .pixel_tick(tick_d),
        .frame_start(fs_d), .vgaRed(rd), .vgaGreen(gd), .vgaBlue(bd),
        .Hsync(hs_d), .Vsync(vs_d)
    );

    // ---------------- fast instance (640x480, CLK_DIV=1) ----------------
    logic        rst_f, tm_f;
    logic [11:0] rgb_f;
    logic [9:0]  xf, yf;
    logic        req_f, tick_f, fs_f, hs_f, vs_f;
    logic [3:0]  rf, gf, bf;

    vga_timing_gen #(
        .CLK_DIV(1)
    ) u_fast (
        .clock(clk), .reset(rst_f), .test_mode(tm_f), .rgb_in(rgb_f),
        .x(xf), .y(yf), .pixel_req(req_f), .pixel_tick(tick_f),
        .frame_start(fs_f), .vgaRed(rf), .vgaGreen(gf), .vgaBlue(bf),
        .Hsync(hs_f), .Vsync(vs_f)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input int cyc,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reset values: counters 0, no tick/frame_start, colour 0, syncs high.
    task automatic chk_rst(input string tag, input int xv, input int yv,
                           input logic tk, input logic fs,
                           input logic [11:0] col, input logic hs, input logic vs);
        chk({tag, "_rst_x"},   0, 32'(xv),  32'd0);
        chk({tag, "_rst_y"},   0, 32'(yv),  32'd0);
        chk({tag, "_rst_tick"},0, 32'(tk),  32'd0);
        chk({tag, "_rst_fs"},  0, 32'(fs),  32'd0);
        chk({tag, "_rst_col"}, 0, 32'(col), 32'd0);
        chk({tag, "_rst_hs"},  0, 32'(hs),  32'd1);
        chk({tag, "_rst_vs"},  0, 32'(vs),  32'd1);
    endtask

    // Small-instance stimulus as a function of pixel index: colour bars in a
    // window that starts and ends mid-line, external pixels elsewhere.
    function automatic logic tm_of(input int m);
        return (m >= 100) && (m < 143);
    endfunction

    function automatic logic [11:0] rgb_of(input int m);
        return ((m % 3) == 0) ? 12'h123 : 12'hABC;
    endfunction

    // Runs the small instance for ncyc clocks from reset release. At sample c
    // (negedge after posedge c) n=(c-1)/2 ticks have completed; x,y describe
    // pixel n, stage-2 outputs describe pixel n-1.
    task automatic run_small(input int ncyc);
        int n, xe, ye, m, xm, ym;
        logic [2:0]  b;
        logic [11:0] ce;
        logic        he, ve;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            n  = (c - 1) / 2;
            xe = n % 14;
            ye = (n / 14) % 7;
            chk("s_tick", c, 32'(tick_s), 32'((c % 2) == 0));
            chk("s_x",    c, 32'(xs),     32'(xe));
            chk("s_y",    c, 32'(ys),     32'(ye));
            chk("s_req",  c, 32'(req_s),  32'((xe < 8) && (ye < 4)));
            chk("s_fs",   c, 32'(fs_s),   32'(((c % 2) == 0) && ((n % 98) == 0)));
            if (n == 0) begin
                ce = 12'h000;
                he = 1'b1;
                ve = 1'b1;
            end else begin
                m  = n - 1;
                xm = m % 14;
                ym = (m / 14) % 7;
                he = !((xm >= 10) && (xm <= 11));
                ve = !(ym == 5);
                if ((xm < 8) && (ym < 4)) begin
                    if (tm_of(m)) begin
                        b  = 3'(xm);
                        ce = {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
                    end else begin
                        ce = rgb_of(m);
                    end
                end else begin
                    ce = 12'h000;
                end
            end
            chk("s_hsync", c, 32'(hs_s), 32'(he));
            chk("s_vsync", c, 32'(vs_s), 32'(ve));
            chk("s_color", c, 32'({rs, gs, bs}), 32'(ce));
            tm_s  = tm_of(n);
            rgb_s = rgb_of(n);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int m;
        logic [11:0] ce;

        rst_s = 1'b1; tm_s = 1'b0; rgb_s = rgb_of(0);
        rst_d = 1'b1; tm_d = 1'b1; rgb_d = 12'h5A5;
        rst_f = 1'b1; tm_f = 1'b0; rgb_f = 12'h3C3;

        // Reset state before any clock edge.
        #2;
        chk_rst("s", 32'(xs), 32'(ys), tick_s, fs_s, {rs, gs, bs}, hs_s, vs_s);
        chk_rst("d", 32'(xd), 32'(yd), tick_d, fs_d, {rd, gd, bd}, hs_d, vs_d);
        chk_rst("f", 32'(xf), 32'(yf), tick_f, fs_f, {rf, gf, bf}, hs_f, vs_f);

        // ---- small: run into a line, stop inside an Hsync pulse, reset ----
        @(negedge clk);
        rst_s = 1'b0;
        run_small(107);              // pixel 52 (x=10,y=3) on the stage-2 outputs
        chk("s_hs_before_rst", 107, 32'(hs_s), 32'd0);
        rst_s = 1'b1;
        #1;
        chk_rst("s_mid", 32'(xs), 32'(ys), tick_s, fs_s, {rs, gs, bs}, hs_s, vs_s);
        @(negedge clk);
        @(negedge clk);
        tm_s  = tm_of(0);
        rgb_s = rgb_of(0);
        rst_s = 1'b0;
        run_small(420);              // two full frames plus a few pixels
        rst_s = 1'b1;

        // ---- default: tick spacing, colour bars, hsync, mid-frame reset ----
        rst_d = 1'b0;
        for (int c = 1; c <= 4402; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk("d_tick_first", c, 32'(tick_d), 32'(c == 4));
                chk("d_fs_first",   c, 32'(fs_d),   32'(c == 4));
                chk("d_x_first",    c, 32'(xd),     32'd0);
            end
            if (c >= 5 && ((c - 5) % 4) == 0) begin
                m = (c - 5) / 4;     // pixel now on the stage-2 outputs
                case (m)
                    0:   chk("d_col_x0",   c, 32'({rd, gd, bd}), 32'h000);
                    79:  chk("d_col_x79",  c, 32'({rd, gd, bd}), 32'h000);
                    80:  chk("d_col_x80",  c, 32'({rd, gd, bd}), 32'h00F);
                    560: chk("d_col_x560", c, 32'({rd, gd, bd}), 32'hFFF);
                    639: chk("d_col_x639", c, 32'({rd, gd, bd}), 32'hFFF);
                    640: chk("d_col_x640", c, 32'({rd, gd, bd}), 32'h000);
                    655: chk("d_hs_x655",  c, 32'(hs_d), 32'd1);
                    656: chk("d_hs_x656",  c, 32'(hs_d), 32'd0);
                    751: chk("d_hs_x751",  c, 32'(hs_d), 32'd0);
                    752: chk("d_hs_x752",  c, 32'(hs_d), 32'd1);
                    default: ;
                endcase
            end
        end
        chk("d_x_at_rst", 4402, 32'(xd), 32'd300);
        chk("d_y_at_rst", 4402, 32'(yd), 32'd1);
        rst_d = 1'b1;
        #1;
        chk_rst("d_mid", 32'(xd), 32'(yd), tick_d, fs_d, {rd, gd, bd}, hs_d, vs_d);
        @(negedge clk);
        rst_d = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("d_re_tick", c, 32'(tick_d), 32'(c == 4));
            chk("d_re_fs",   c, 32'(fs_d),   32'(c == 4));
            chk("d_re_x",    c, 32'(xd),     32'(c == 5));
            chk("d_re_y",    c, 32'(yd),     32'd0);
        end
        rst_d = 1'b1;

        // ---- fast: constant tick, same sync columns in tick units ----
        rst_f = 1'b0;
        for (int c = 1; c <= 802; c++) begin
            @(negedge clk);
            chk("f_tick", c, 32'(tick_f), 32'd1);
            if (c == 1)   chk("f_fs_x0",   c, 32'(fs_f), 32'd1);
            if (c == 2)   chk("f_fs_x1",   c, 32'(fs_f), 32'd0);
            if (c == 800) chk("f_x_last",  c, 32'(xf),   32'd799);
            if (c == 800) chk("f_y_line0", c, 32'(yf),   32'd0);
            if (c == 801) chk("f_x_wrap",  c, 32'(xf),   32'd0);
            if (c == 801) chk("f_y_line1", c, 32'(yf),   32'd1);
            if (c == 657) chk("f_hs_x655", c, 32'(hs_f), 32'd1);
            if (c == 658) chk("f_hs_x656", c, 32'(hs_f), 32'd0);
            if (c == 753) chk("f_hs_x751", c, 32'(hs_f), 32'd0);
            if (c == 754) chk("f_hs_x752", c, 32'(hs_f), 32'd1);
            if (c == 42) begin
                ce = 12'h000;        // pixel 40, bar 0, test_mode=0 -> rgb_in
                chk("f_col_ext", c, 32'({rf, gf, bf}), 32'h3C3);
                chk("f_col_ref", c, 32'(ce), 32'h000);
            end
        end
        rst_f = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Backstop: the directed sequence is a few thousand clocks long.
    initial begin
        #2000000;
        $display("FAIL watchdog: sequence did not complete");
        $fatal(1, "watchdog");
    end

endmodule
